// File: rtl/trng_pkg.sv
// Shared types and default parameter values for the TRNG harvester.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAIL    = 3'd4
    } state_e;

    localparam int DEF_NUM_CELLS  = 8;
    localparam int DEF_WORD_W     = 8;
    localparam int DEF_WARMUP_CYC = 16;
    localparam int DEF_REP_LIMIT  = 32;

endpackage

// File: rtl/trng_harvester_if.sv
// Control, test-injection and output-word handshake bundle for trng_harvester.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready; the producer holds out_data until accepted.
// Ports: enable, mode_raw, tst_en, tst_bit, out_ready (to harvester);
//        out_data, out_valid, busy, health_fail (from harvester).
interface trng_harvester_if
    import trng_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic              enable;
    logic              mode_raw;
    logic              tst_en;
    logic              tst_bit;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              health_fail;

    // master: the controlling / consuming side
    modport master (
        output enable, mode_raw, tst_en, tst_bit, out_ready,
        input  out_data, out_valid, busy, health_fail
    );

    // slave: the harvester itself
    modport slave (
        input  enable, mode_raw, tst_en, tst_bit, out_ready,
        output out_data, out_valid, busy, health_fail
    );
endinterface

// File: rtl/metastable_cell.sv
// Behavioural entropy cell: SR element forced by s/r, racing when both are driven.
// Latency: 1 cycle from s/r to q.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), s (set), r (reset), q (cell output).
module metastable_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);
    logic q_q, q_d;

    // In silicon s=r=1 resolves unpredictably; the RTL model toggles so that the
    // cell is live but deterministic in simulation.
    always_comb begin
        q_d = q_q;
        case ({s, r})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/trng_harvester.sv
// Harvests entropy cells into words: warm-up discard, optional von Neumann debias, repetition health test.
// Latency: sample reaches the debiaser 2 cycles after injection; out_valid rises the cycle after the last bit.
// Backpressure: word held in HOLD until out_valid & out_ready; collection pauses meanwhile.
// Ports: clk, rst (sync, active-high), bus (trng_harvester_if.slave).
module trng_harvester
    import trng_pkg::*;
#(
    parameter int NUM_CELLS  = DEF_NUM_CELLS,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int WARMUP_CYC = DEF_WARMUP_CYC,
    parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    trng_harvester_if.slave   bus
);
    localparam int         CNT_W     = $clog2(WORD_W + 1);
    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYC - 1);
    localparam logic [7:0] REP_LIM   = 8'(REP_LIMIT);

    state_e            state_q, state_d;
    logic              mode_raw_q, mode_raw_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [7:0]        warm_cnt_q, warm_cnt_d;
    logic [7:0]        rep_cnt_q, rep_cnt_d;
    logic              rep_last_q, rep_last_d;
    logic              pair_have_q, pair_have_d;
    logic              pair_first_q, pair_first_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              health_q, health_d;

    logic                 cells_run;
    logic [NUM_CELLS-1:0] cell_q;
    logic                 sample;
    logic [7:0]           rep_next;
    logic                 rep_fail;
    logic                 emit;
    logic                 emit_bit;
    logic                 to_idle;

    // Cells race only while the harvester is sampling; otherwise held reset.
    assign cells_run = (state_q == ST_WARMUP) || (state_q == ST_COLLECT) ||
                       (state_q == ST_HOLD);

    genvar g;
    generate
        for (g = 0; g < NUM_CELLS; g++) begin : g_cell
            metastable_cell u_cell (
                .clk (clk),
                .rst (rst),
                .s   (cells_run),
                .r   (1'b1),
                .q   (cell_q[g])
            );
        end
    endgenerate

    assign sample = sync2_q;

    always_comb begin
        state_d      = state_q;
        mode_raw_d   = mode_raw_q;
        sync1_d      = bus.tst_en ? bus.tst_bit : ^cell_q;
        sync2_d      = sync1_q;
        warm_cnt_d   = warm_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        rep_last_d   = rep_last_q;
        pair_have_d  = pair_have_q;
        pair_first_d = pair_first_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        valid_d      = valid_q;
        health_d     = health_q;
        rep_next     = 8'd1;
        rep_fail     = 1'b0;
        emit         = 1'b0;
        emit_bit     = 1'b0;
        to_idle      = 1'b0;

        // Repetition test runs on every sample taken, including while a word waits in HOLD.
        if (cells_run) begin
            if ((rep_cnt_q != 8'd0) && (sample == rep_last_q)) begin
                rep_next = rep_cnt_q + 8'd1;
            end
            rep_cnt_d  = rep_next;
            rep_last_d = sample;
            rep_fail   = (rep_next == REP_LIM);
        end

        // A health failure overrides enable changes and a same-cycle handshake;
        // the held word is simply dropped.
        if (rep_fail) begin
            state_d  = ST_FAIL;
            health_d = 1'b1;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rep_cnt_d = 8'd0;
                    if (bus.enable) begin
                        state_d    = ST_WARMUP;
                        mode_raw_d = bus.mode_raw;
                        warm_cnt_d = 8'd0;
                    end
                end
                ST_WARMUP: begin
                    if (!bus.enable) begin
                        to_idle = 1'b1;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 8'd1;
                        if (warm_cnt_q == WARM_LAST) begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (!bus.enable) begin
                        to_idle = 1'b1;
                    end else begin
                        if (mode_raw_q) begin
                            emit     = 1'b1;
                            emit_bit = sample;
                        end else if (!pair_have_q) begin
                            pair_have_d  = 1'b1;
                            pair_first_d = sample;
                        end else begin
                            // Non-overlapping pairs: 01 -> 0, 10 -> 1, equal pairs dropped.
                            pair_have_d = 1'b0;
                            if (pair_first_q != sample) begin
                                emit     = 1'b1;
                                emit_bit = pair_first_q;
                            end
                        end
                        if (emit) begin
                            data_d    = (data_q << 1) | WORD_W'(emit_bit);
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                                valid_d     = 1'b1;
                                state_d     = ST_HOLD;
                                pair_have_d = 1'b0;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    pair_have_d = 1'b0;
                    // enable is ignored here: the word is only released by a handshake.
                    if (valid_q && bus.out_ready) begin
                        valid_d   = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = bus.enable ? ST_COLLECT : ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (to_idle) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            pair_have_d = 1'b0;
            data_d      = '0;
            rep_cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_raw_q   <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            warm_cnt_q   <= 8'd0;
            rep_cnt_q    <= 8'd0;
            rep_last_q   <= 1'b0;
            pair_have_q  <= 1'b0;
            pair_first_q <= 1'b0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            health_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_raw_q   <= mode_raw_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            warm_cnt_q   <= warm_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            rep_last_q   <= rep_last_d;
            pair_have_q  <= pair_have_d;
            pair_first_q <= pair_first_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            health_q     <= health_d;
        end
    end

    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.health_fail = health_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Directed + randomized bench for trng_harvester with a sample-stream reference model.
// Latency: n/a.
// Backpressure: bench drives out_ready explicitly.
module tb_trng_harvester;
    localparam int WW   = 8;
    localparam int WARM = 4;
    localparam int RL   = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    bit   seq[$];
    logic [WW-1:0] held;

    trng_harvester_if #(.WORD_W(WW)) bus ();

    trng_harvester #(
        .NUM_CELLS  (8),
        .WORD_W     (WW),
        .WARMUP_CYC (WARM),
        .REP_LIMIT  (RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: seq[m] is the m-th sample the harvester consumes after enable.
    // Drop WARM samples, then take raw bits or von Neumann pairs until a word is full.
    function automatic void model(input bit raw, output logic [WW-1:0] word, output int last_m);
        int nb;
        nb     = 0;
        word   = '0;
        last_m = -1;
        if (raw) begin
            for (int m = WARM; m < seq.size() && nb < WW; m++) begin
                word   = {word[WW-2:0], seq[m]};
                nb++;
                last_m = m;
            end
        end else begin
            for (int m = WARM; m + 1 < seq.size() && nb < WW; m += 2) begin
                if (seq[m] != seq[m+1]) begin
                    word   = {word[WW-2:0], seq[m]};
                    nb++;
                    last_m = m + 1;
                end
            end
        end
        if (nb < WW) last_m = -1;
    endfunction

    // Sample k of the stream is driven two cycles before it is consumed, so
    // enable goes high with element 1 and element m is taken at loop step m+2.
    task automatic run_word(input bit raw, input string tag);
        logic [WW-1:0] exp_w;
        int            exp_m;
        int            got_k;
        got_k = -1;
        model(raw, exp_w, exp_m);
        bus.mode_raw = raw;
        for (int k = 0; k < seq.size(); k++) begin
            bus.tst_bit = seq[k];
            if (k == 1) bus.enable = 1'b1;
            if (k == 3) bus.mode_raw = ~raw;  // must be ignored after IDLE
            tick();
            if (bus.out_valid) begin
                got_k = k;
                break;
            end
        end
        check({tag, "_latency"}, got_k, exp_m + 2);
        check({tag, "_data"}, bus.out_data, exp_w);
    endtask

    task automatic consume_to_idle(input string tag);
        bus.enable    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_valid_fall"}, bus.out_valid, 1'b0);
        check({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic gen_raw(input int n);
        seq = {};
        for (int i = 0; i < n; i++) seq.push_back(1'($urandom_range(0, 1)));
    endtask

    initial begin
        int  nvalid;
        bit  a;
        bit  b;

        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.mode_raw  = 1'b1;
        bus.tst_en    = 1'b1;
        bus.tst_bit   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_health", bus.health_fail, 1'b0);
        rst = 1'b0;
        tick();

        // Directed raw word 1,0,1,1,0,0,1,0 after warm-up
        seq = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        run_word(1'b1, "raw_b2");
        check("raw_b2_const", bus.out_data, 8'hB2);
        // enable dropped in HOLD with no ready: word must persist
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.tst_bit = ~bus.tst_bit;
            tick();
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data", bus.out_data, 8'hB2);
        end
        consume_to_idle("b2");

        // Randomized raw words
        for (int it = 0; it < 3; it++) begin
            gen_raw(WARM + WW + 3);
            run_word(1'b1, "raw_rand");
            consume_to_idle("raw_rand");
        end

        // Debiased: directed pairs 01,10,00,11,10 then random pairs
        seq = {};
        for (int i = 0; i < WARM; i++) seq.push_back(1'($urandom_range(0, 1)));
        seq.push_back(1'b0); seq.push_back(1'b1);
        seq.push_back(1'b1); seq.push_back(1'b0);
        seq.push_back(1'b0); seq.push_back(1'b0);
        seq.push_back(1'b1); seq.push_back(1'b1);
        seq.push_back(1'b1); seq.push_back(1'b0);
        nvalid = 3;
        while (nvalid < WW) begin
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            seq.push_back(a);
            seq.push_back(b);
            if (a != b) nvalid++;
        end
        for (int i = 0; i < 4; i++) seq.push_back(1'($urandom_range(0, 1)));
        run_word(1'b0, "vn");
        check("vn_prefix", 32'(bus.out_data[7:5]), 32'd3);
        // Handshake with enable still high resumes collection
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("vn_resume_valid", bus.out_valid, 1'b0);
        check("vn_resume_busy", bus.busy, 1'b1);
        bus.enable = 1'b0;
        tick();
        check("vn_drop_idle", bus.busy, 1'b0);

        // Enable dropped after 5 of 8 bits, then a clean restart
        gen_raw(11);
        bus.mode_raw = 1'b1;
        for (int k = 0; k < 11; k++) begin
            bus.tst_bit = seq[k];
            if (k == 1) bus.enable = 1'b1;
            tick();
        end
        check("partial_no_valid", bus.out_valid, 1'b0);
        bus.enable = 1'b0;
        tick();
        check("partial_idle", bus.busy, 1'b0);
        gen_raw(WARM + WW + 3);
        run_word(1'b1, "restart");
        held = bus.out_data;

        // Reset in HOLD
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        bus.enable = 1'b0;
        check("rsthold_valid", bus.out_valid, 1'b0);
        check("rsthold_data", bus.out_data, 8'h00);
        check("rsthold_busy", bus.busy, 1'b0);
        tick();

        // Stuck-at-1 source: 32nd identical sample trips the test while a word is held,
        // coinciding with a handshake that must lose.
        bus.mode_raw = 1'b1;
        bus.tst_bit  = 1'b1;
        for (int k = 0; k <= RL + 1; k++) begin
            if (k == 1) bus.enable = 1'b1;
            if (k == RL + 1) begin
                bus.out_ready = 1'b1;
                bus.enable    = 1'b0;
            end
            tick();
            if (k == WARM + WW + 1) begin
                check("stuck_word_valid", bus.out_valid, 1'b1);
                check("stuck_word_data", bus.out_data, 8'hFF);
            end
            if (k == RL) check("stuck_before_limit", bus.health_fail, 1'b0);
        end
        check("stuck_health", bus.health_fail, 1'b1);
        check("stuck_valid_low", bus.out_valid, 1'b0);
        check("stuck_fail_busy", bus.busy, 1'b1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.tst_bit = ~bus.tst_bit;
            bus.enable  = ~bus.enable;
            tick();
        end
        check("sticky_health", bus.health_fail, 1'b1);
        check("sticky_valid", bus.out_valid, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("fail_cleared", bus.health_fail, 1'b0);
        check("fail_idle", bus.busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
